// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - game flow controller signal bundle
interface game_sequencer_if;
  logic        go;
  logic        stop;
  logic        jump_btn;
  logic        frame_done;
  logic [1:0]  runner_h;
  logic [1:0]  obstacle_h;
  logic        start;
  logic        step;
  logic        jump_req;
  logic [27:0] rate_cur;
  logic [15:0] score;
  logic [2:0]  state_out;
  logic        game_over;

  modport master (
    output go, stop, jump_btn, frame_done, runner_h, obstacle_h,
    input  start, step, jump_req, rate_cur, score, state_out, game_over
  );

  modport slave (
    input  go, stop, jump_btn, frame_done, runner_h, obstacle_h,
    output start, step, jump_req, rate_cur, score, state_out, game_over
  );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - dot-runner game flow: scroll timing, jumps, collision, BCD score
module game_sequencer #(
  parameter logic [27:0] RATE_INIT = 28'd3000000,
  parameter logic [27:0] RATE_MIN  = 28'd750000,
  parameter logic [27:0] RATE_STEP = 28'd250000,
  parameter logic [25:0] HIT_HOLD  = 26'd50000000
) (
  input  logic                   clk,
  input  logic                   resetn,
  game_sequencer_if.slave        bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CHECK = 3'd4;
  localparam logic [2:0] S_HIT   = 3'd5;
  localparam logic [2:0] S_OVER  = 3'd6;

  logic [2:0]  state;
  logic [27:0] counter;
  logic [27:0] rate_cur;
  logic [25:0] hold;
  logic [15:0] score;
  logic        step;
  logic        jump_req;
  logic        jump_pending;
  logic        jump_prev;
  logic        jump_edge;
  logic        digit0_wrap;
  logic [15:0] score_next;
  logic [27:0] rate_next;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign jump_edge = bus.jump_btn & ~jump_prev;

  // Saturated score never wraps digit 0, so it never speeds the game up either.
  always_comb begin
    digit0_wrap = 1'b0;
    score_next  = score;
    rate_next   = rate_cur;
    if (score != 16'h9999) begin
      score_next  = bcd_inc(score);
      digit0_wrap = (score[3:0] == 4'd9);
    end
    if (digit0_wrap) begin
      rate_next = (rate_cur < RATE_MIN + RATE_STEP) ? RATE_MIN : rate_cur - RATE_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= S_IDLE;
      counter      <= RATE_INIT;
      rate_cur     <= RATE_INIT;
      hold         <= '0;
      score        <= '0;
      step         <= 1'b0;
      jump_req     <= 1'b0;
      jump_pending <= 1'b0;
      jump_prev    <= 1'b0;
    end else begin
      step      <= 1'b0;
      jump_req  <= 1'b0;
      jump_prev <= bus.jump_btn;
      case (state)
        S_IDLE: begin
          if (bus.go) state <= S_ARM;
        end
        S_ARM: begin
          score        <= '0;
          rate_cur     <= RATE_INIT;
          counter      <= RATE_INIT;
          jump_pending <= 1'b0;
          state        <= S_RUN;
        end
        S_RUN: begin
          if (bus.stop) begin
            state <= S_OVER;
          end else begin
            if (jump_edge) jump_pending <= 1'b1;
            if (counter == '0) state <= S_WAIT;
            else               counter <= counter - 28'd1;
          end
        end
        S_WAIT: begin
          if (bus.stop) begin
            state <= S_OVER;
          end else if (bus.frame_done) begin
            step         <= 1'b1;
            jump_req     <= jump_pending;
            // an edge coinciding with this step belongs to the next one
            jump_pending <= jump_edge;
            state        <= S_CHECK;
          end else if (jump_edge) begin
            jump_pending <= 1'b1;
          end
        end
        S_CHECK: begin
          if (bus.stop) begin
            state <= S_OVER;
          end else if (bus.obstacle_h > bus.runner_h) begin
            hold  <= HIT_HOLD - 26'd1;
            state <= S_HIT;
          end else begin
            score    <= score_next;
            rate_cur <= rate_next;
            counter  <= rate_next;
            state    <= S_RUN;
          end
        end
        S_HIT: begin
          if (bus.stop || hold == '0) state <= S_OVER;
          else                        hold  <= hold - 26'd1;
        end
        S_OVER: begin
          if (bus.go) state <= S_ARM;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start     = (state == S_IDLE);
  assign bus.game_over = (state == S_OVER);
  assign bus.state_out = state;
  assign bus.step      = step;
  assign bus.jump_req  = jump_req;
  assign bus.score     = score;
  assign bus.rate_cur  = rate_cur;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - scoreboard bench for game_sequencer
`timescale 1ns/1ps
module tb_game_sequencer;

  localparam int RI = 4;
  localparam int RM = 2;
  localparam int RS = 1;
  localparam int HH = 3;

  typedef struct {
    logic        jr;
    logic [15:0] score;
    logic [27:0] rate;
    logic [2:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  game_sequencer_if bus();

  game_sequencer #(
    .RATE_INIT(28'(RI)), .RATE_MIN(28'(RM)), .RATE_STEP(28'(RS)), .HIT_HOLD(26'(HH))
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_asserts = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   post_chk = 0;
  int   n_clean;
  int   model_rate;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_state"}, bus.state_out, 0);
    check({pfx, "_start"}, bus.start, 1);
    check({pfx, "_step"}, bus.step, 0);
    check({pfx, "_jreq"}, bus.jump_req, 0);
    check({pfx, "_score"}, bus.score, 0);
    check({pfx, "_rate"}, bus.rate_cur, RI);
    check({pfx, "_over"}, bus.game_over, 0);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int i = 0;
    while (bus.state_out != s && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (bus.state_out != s) check(tag, bus.state_out, s);
  endtask

  // Drive one frame_done in WAIT_FRAME and queue what the step must produce.
  task automatic do_step(input bit collide, input bit jr_exp);
    exp_t e;
    wait_state(3'd3, "wait_frame_timeout");
    if (bus.state_out != 3'd3) return;
    if (collide) begin
      bus.obstacle_h = 2'd2;
      bus.runner_h   = 2'd1;
      e.st = 3'd5;
    end else begin
      if (n_clean < 9999) begin
        n_clean++;
        if (n_clean % 10 == 0) model_rate = (model_rate < RM + RS) ? RM : model_rate - RS;
      end
      e.st = 3'd2;
    end
    e.jr    = jr_exp;
    e.score = to_bcd(n_clean);
    e.rate  = 28'(model_rate);
    exp_q.push_back(e);
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
  endtask

  always @(negedge clk) begin
    if (post_chk) begin
      check("post_score", bus.score, cur.score);
      check("post_rate", bus.rate_cur, cur.rate);
      check("post_state", bus.state_out, cur.st);
      post_chk = 0;
    end
    if (bus.jump_req && !bus.step) check("jreq_without_step", 1, 0);
    if (bus.step) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        check("jump_req", bus.jump_req, cur.jr);
        post_chk = 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run_n;
    int hit_n;
    resetn = 1'b0;
    bus.go = 0; bus.stop = 0; bus.jump_btn = 0; bus.frame_done = 0;
    bus.runner_h = 0; bus.obstacle_h = 0;
    n_clean = 0;
    model_rate = RI;
    repeat (3) @(negedge clk);
    check_reset("rst");
    resetn = 1'b1;
    @(negedge clk);
    check("idle_hold", bus.state_out, 0);

    // 1: start, RUN length, first step
    bus.go = 1'b1;
    @(negedge clk);
    check("arm", bus.state_out, 1);
    bus.go = 1'b0;
    @(negedge clk);
    run_n = 0;
    while (bus.state_out == 3'd2 && run_n < 20) begin
      run_n++;
      @(negedge clk);
    end
    check("run_len", run_n, 5);
    check("wait_frame", bus.state_out, 3);
    do_step(0, 0);
    @(negedge clk);
    check("score_1", bus.score, 16'h0001);

    // 2: speed-up and floor
    repeat (9) do_step(0, 0);
    @(negedge clk);
    check("score_10", bus.score, 16'h0010);
    check("rate_10", bus.rate_cur, 3);
    repeat (20) do_step(0, 0);
    @(negedge clk);
    check("rate_30", bus.rate_cur, 2);
    repeat (10) do_step(0, 0);
    @(negedge clk);
    check("score_40", bus.score, 16'h0040);
    check("rate_40", bus.rate_cur, 2);

    // 3: two jump edges collapse into one request
    bus.jump_btn = 1; @(negedge clk);
    bus.jump_btn = 0; @(negedge clk);
    bus.jump_btn = 1; @(negedge clk);
    bus.jump_btn = 0;
    do_step(0, 1);
    do_step(0, 0);

    // 4: collision, HIT hold, OVER, restart
    do_step(1, 0);
    @(negedge clk);
    hit_n = 0;
    while (bus.state_out == 3'd5 && hit_n < 20) begin
      hit_n++;
      @(negedge clk);
    end
    bus.obstacle_h = 0;
    bus.runner_h = 0;
    check("hit_len", hit_n, HH);
    check("over_state", bus.state_out, 6);
    check("over_flag", bus.game_over, 1);
    check("over_score", bus.score, to_bcd(n_clean));
    bus.go = 1'b1;
    @(negedge clk);
    check("rearm", bus.state_out, 1);
    bus.go = 1'b0;
    @(negedge clk);
    check("rearm_score", bus.score, 0);
    check("rearm_rate", bus.rate_cur, RI);
    n_clean = 0;
    model_rate = RI;

    // 5: stop beats frame_done
    wait_state(3'd3, "t5_wait_timeout");
    bus.stop = 1'b1;
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.frame_done = 1'b0;
    check("stop_state", bus.state_out, 6);
    check("stop_step", bus.step, 0);
    check("stop_score", bus.score, 0);
    check("stop_over", bus.game_over, 1);

    // 6: saturation at 9999, then reset mid-RUN
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (9998) do_step(0, 0);
    @(negedge clk);
    check("score_9998", bus.score, 16'h9998);
    do_step(0, 0);
    @(negedge clk);
    check("score_9999", bus.score, 16'h9999);
    do_step(0, 0);
    @(negedge clk);
    check("score_sat", bus.score, 16'h9999);
    check("sat_rate", bus.rate_cur, RM);
    wait_state(3'd2, "t6_run_timeout");
    resetn = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    resetn = 1'b1;
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
